output_wrr_scheduler: RTL and testbench
=======================================

// Module: output_wrr_scheduler
// PURPOSE
// Packet-level weighted round-robin scheduler for the per-virtual-switch output FIFOs feeding the output queues.
// Reads only FIFO status and m_axis_tready. Drives the FIFO read enables and the output mux select.
// Never switches queues mid-packet. Gives per-queue bandwidth shares in packets, set by configurable weights.
// Keeps a forwarded-packet counter for each queue.
// PARAMETERS
// NUM_QUEUES     5   number of input FIFOs (virtual switch outputs incl. DMA path)
// WEIGHT_WIDTH   8   bits per queue weight / credit counter
// CNT_WIDTH      32  bits per per-queue packet counter
// SEL_WIDTH      log2(NUM_QUEUES) (local)  width of queue select
// PORTS
// axis_aclk      in   1                        clock
// axis_resetn    in   1                        async active-low reset
// q_empty        in   NUM_QUEUES               per-FIFO empty flag (head word invalid when 1)
// q_tlast        in   NUM_QUEUES               tlast of each FIFO head word
// m_axis_tready  in   1                        downstream ready
// cfg_weight     in   NUM_QUEUES*WEIGHT_WIDTH  packets per turn, queue i at [i*W +: W]; 0 = disabled
// rd_en          out  NUM_QUEUES               FIFO pop strobes (one-hot or zero)
// out_sel        out  SEL_WIDTH                current queue; drives tdata/tkeep/tuser/tlast mux
// m_axis_tvalid  out  1                        valid for muxed head word
// pkt_fwd        out  1                        one-cycle pulse, registered, per packet start
// pkt_cnt        out  NUM_QUEUES*CNT_WIDTH     packets completed per queue, queue i at [i*C +: C]
// BEHAVIOUR
// - Reset (async assert, sync deassert use): state=IDLE, cur_queue=0, credit=0, pkt_fwd=0, pkt_cnt=0. rd_en=0 and m_axis_tvalid=0 while reset is held.
// - eligible(i) = ~q_empty[i] & (cfg_weight[i]!=0).
// - next = the first eligible queue scanning cur+1, cur+2, ... with wrap; cur itself is checked last. Scan is combinational.
// - IDLE, serve case: eligible(cur) & credit!=0.
//     m_axis_tvalid=1. rd_en[cur]=m_axis_tready.
//     On pop: pkt_fwd=1 next cycle.
//     If q_tlast[cur]=1: stay IDLE, credit-=1, pkt_cnt[cur]+=1.
//     Else: go to WR_PKT.
// - IDLE, otherwise: m_axis_tvalid=0, rd_en=0.
//     If a next exists: cur<=next, credit<=cfg_weight[next]. This costs 1 bubble cycle.
//     If none exists: hold cur and credit.
// - WR_PKT: m_axis_tvalid=~q_empty[cur]. rd_en[cur]=m_axis_tready&~q_empty[cur].
//     On pop with q_tlast[cur]: go to IDLE, credit-=1, pkt_cnt[cur]+=1.
//     An empty FIFO mid-packet stalls the scheduler; it does not switch queues.
// - A weight change takes effect at the next credit reload. The current turn keeps its loaded credit.
// - Credit never underflows: decrement happens only when credit!=0.
// - pkt_cnt wraps modulo 2^CNT_WIDTH with no saturation.
// - out_sel=cur_queue in every state.
// - Latency: combinational pop in the same cycle as tready. No added data latency.
// - Reset mid-packet: all state cleared immediately. FIFO contents are not this block's concern.
// TESTING
// 1) Weights {2,1,1,0,0}, q0-q2 always backlogged with 1-word pkts, tready=1.
//    -> service order 0,0,1,2,0,0,1,2...
//    -> q3/q4 rd_en never asserted.
// 2) q0 has a 4-word pkt, tready toggles 1/0, q1 non-empty.
//    -> out_sel stays 0 until the 4th pop.
//    -> rd_en[0] fires exactly 4 times.
//    -> pkt_fwd pulses once.
//    -> pkt_cnt[0]=1.
// 3) Only q2 eligible, weight 1, 1-word pkts back-to-back.
//    -> pops every 2nd cycle (credit reload bubble).
//    -> out_sel held at 2.
// 4) Mid-packet, q0 FIFO goes empty for 3 cycles.
//    -> m_axis_tvalid=0 for 3 cycles.
//    -> no queue switch.
//    -> packet resumes on q0.
// 5) axis_resetn asserted mid-packet, 3rd word of 5.
//    -> rd_en=0, out_sel=0, pkt_cnt all 0 immediately.
//    -> IDLE after release.
// 6) Preload pkt_cnt[1]=2^32-1 (force), send 1 pkt on q1.
//    -> pkt_cnt[1]=0.

Source files
------------

// File: rtl/output_wrr_scheduler.sv
// Packet-level weighted round-robin scheduler for per-virtual-switch output FIFOs.
// Pops FIFO heads combinationally on tready and never switches queues mid-packet.
module output_wrr_scheduler #(
    parameter int NUM_QUEUES   = 5,
    parameter int WEIGHT_WIDTH = 8,
    parameter int CNT_WIDTH    = 32,
    localparam int SEL_WIDTH   = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                               axis_aclk,
    input  logic                               axis_resetn,
    input  logic [NUM_QUEUES-1:0]              q_empty,
    input  logic [NUM_QUEUES-1:0]              q_tlast,
    input  logic                               m_axis_tready,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] cfg_weight,
    output logic [NUM_QUEUES-1:0]              rd_en,
    output logic [SEL_WIDTH-1:0]               out_sel,
    output logic                               m_axis_tvalid,
    output logic                               pkt_fwd,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]    pkt_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        WR_PKT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SEL_WIDTH-1:0]    cur_queue;
    logic [SEL_WIDTH-1:0]    cur_next;
    logic [SEL_WIDTH-1:0]    next_queue;
    logic                    next_found;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic [WEIGHT_WIDTH-1:0] credit_next;
    logic [WEIGHT_WIDTH-1:0] weight [NUM_QUEUES];
    logic [CNT_WIDTH-1:0]    cnt    [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]   eligible;
    logic                    cur_empty;
    logic                    cur_tlast;
    logic                    cur_eligible;
    logic                    credit_live;
    logic                    pop;
    logic                    pkt_start;
    logic                    pkt_done;
    int                      idx;

    // Unpack weights, flag eligible queues and pack the counters back out
    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
        assign weight[g]   = cfg_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign eligible[g] = ~q_empty[g] & (weight[g] != '0);
        assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end

    assign cur_empty    = q_empty[cur_queue];
    assign cur_tlast    = q_tlast[cur_queue];
    assign cur_eligible = eligible[cur_queue];
    assign credit_live  = (credit != '0);
    assign out_sel      = cur_queue;

    // Find the first eligible queue after cur, wrapping, with cur itself last
    always_comb begin
        next_found = 1'b0;
        next_queue = cur_queue;
        idx        = 0;
        for (int k = NUM_QUEUES; k >= 1; k--) begin
            idx = (int'(cur_queue) + k) % NUM_QUEUES;
            if (eligible[idx]) begin
                next_found = 1'b1;
                next_queue = SEL_WIDTH'(idx);
            end
        end
    end

    // Next-state, credit reload and handshake outputs
    always_comb begin
        state_next    = state;
        cur_next      = cur_queue;
        credit_next   = credit;
        m_axis_tvalid = 1'b0;
        rd_en         = '0;
        pop           = 1'b0;
        pkt_start     = 1'b0;
        pkt_done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cur_eligible && credit_live) begin
                    m_axis_tvalid = 1'b1;
                    if (m_axis_tready) begin
                        pop       = 1'b1;
                        pkt_start = 1'b1;
                        if (cur_tlast) begin
                            pkt_done = 1'b1;
                        end else begin
                            state_next = WR_PKT;
                        end
                    end
                end else if (next_found) begin
                    cur_next    = next_queue;
                    credit_next = weight[next_queue];
                end
            end
            WR_PKT: begin
                m_axis_tvalid = ~cur_empty;
                if (m_axis_tready && !cur_empty) begin
                    pop = 1'b1;
                    if (cur_tlast) begin
                        pkt_done   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
        endcase
        if (pkt_done && credit_live) begin
            credit_next = credit - WEIGHT_WIDTH'(1);
        end
        if (pop) begin
            rd_en[cur_queue] = 1'b1;
        end
    end

    // Scheduler state, credit and the packet-start pulse
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state     <= IDLE;
            cur_queue <= '0;
            credit    <= '0;
            pkt_fwd   <= 1'b0;
        end else begin
            state     <= state_next;
            cur_queue <= cur_next;
            credit    <= credit_next;
            pkt_fwd   <= pkt_start;
        end
    end

    // Per-queue completed-packet counters, wrapping freely
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (pkt_done && (cur_queue == SEL_WIDTH'(i))) begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_output_wrr_scheduler.sv
// Randomized bench for output_wrr_scheduler against a packet-level WRR model.
// A narrow-counter second instance shares stimulus to exercise counter wrap.
module tb_output_wrr_scheduler;

    localparam int NQ = 5;
    localparam int W  = 8;
    localparam int C  = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NQ-1:0]   q_empty;
    logic [NQ-1:0]   q_tlast;
    logic            tready;
    logic [NQ*W-1:0] cfg_weight;
    logic [NQ-1:0]   rd_en, rd_en_w;
    logic [2:0]      out_sel, out_sel_w;
    logic            tvalid, tvalid_w;
    logic            fwd, fwd_w;
    logic [NQ*C-1:0]  pkt_cnt;
    logic [NQ*CW-1:0] pkt_cnt_w;

    output_wrr_scheduler #(
        .NUM_QUEUES(NQ), .WEIGHT_WIDTH(W), .CNT_WIDTH(C)
    ) dut (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .q_empty(q_empty), .q_tlast(q_tlast),
        .m_axis_tready(tready), .cfg_weight(cfg_weight),
        .rd_en(rd_en), .out_sel(out_sel),
        .m_axis_tvalid(tvalid), .pkt_fwd(fwd),
        .pkt_cnt(pkt_cnt)
    );

    output_wrr_scheduler #(
        .NUM_QUEUES(NQ), .WEIGHT_WIDTH(W), .CNT_WIDTH(CW)
    ) dut_w (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .q_empty(q_empty), .q_tlast(q_tlast),
        .m_axis_tready(tready), .cfg_weight(cfg_weight),
        .rd_en(rd_en_w), .out_sel(out_sel_w),
        .m_axis_tvalid(tvalid_w), .pkt_fwd(fwd_w),
        .pkt_cnt(pkt_cnt_w)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    bit          fq [NQ][$];
    int          order [$];
    int          wt [NQ];
    bit          backlog [NQ];
    int          mode;
    int          m_cur;
    int          m_credit;
    bit          m_inpkt;
    bit          m_fwd;
    logic [C-1:0] m_cnt [NQ];
    bit          obs_tv;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input int q, input int len);
        for (int j = 0; j < len; j++) fq[q].push_back(j == len - 1);
    endtask

    task automatic drive_flags();
        for (int i = 0; i < NQ; i++) begin
            q_empty[i] = (fq[i].size() == 0);
            q_tlast[i] = (fq[i].size() > 0) ? fq[i][0] : 1'b0;
        end
    endtask

    task automatic set_w(input int a, input int b, input int c,
                         input int d, input int e);
        cfg_weight = {W'(e), W'(d), W'(c), W'(b), W'(a)};
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NQ; i++) begin
            fq[i].delete();
            backlog[i] = 1'b0;
        end
        order.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_flags();
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_fwd", fwd, 0);
        check("rst_cnt_any", |pkt_cnt, 0);
        m_cur = 0;
        m_credit = 0;
        m_inpkt = 1'b0;
        m_fwd = 1'b0;
        for (int i = 0; i < NQ; i++) m_cnt[i] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock of stimulus, comparison and model update
    task automatic step();
        bit serve;
        bit found;
        bit t;
        int nxt;
        int pick;
        logic [NQ-1:0] e_rd;
        bit e_tv;
        check("pkt_fwd", fwd, m_fwd);
        check("pkt_fwd_w", fwd_w, m_fwd);
        for (int i = 0; i < NQ; i++) begin
            check($sformatf("pkt_cnt%0d", i), pkt_cnt[i*C +: C], m_cnt[i]);
            check($sformatf("pkt_cnt_w%0d", i), pkt_cnt_w[i*CW +: CW],
                  64'(m_cnt[i][CW-1:0]));
        end
        if (mode == 0) begin
            for (int i = 0; i < NQ; i++)
                if (backlog[i] && fq[i].size() < 2) push_pkt(i, 1);
        end else if (mode == 1) begin
            for (int i = 0; i < NQ; i++) begin
                if ($urandom_range(0, 3) == 0 && fq[i].size() < 12)
                    push_pkt(i, $urandom_range(1, 4));
                if ($urandom_range(0, 59) == 0)
                    cfg_weight[i*W +: W] = W'($urandom_range(0, 3));
            end
            tready = ($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < NQ; i++) wt[i] = int'(cfg_weight[i*W +: W]);
        drive_flags();
        #1;
        serve = 1'b0;
        e_rd = '0;
        e_tv = 1'b0;
        if (!m_inpkt) begin
            serve = fq[m_cur].size() > 0 && wt[m_cur] != 0 && m_credit > 0;
            if (serve) begin
                e_tv = 1'b1;
                if (tready) e_rd[m_cur] = 1'b1;
            end
        end else begin
            e_tv = fq[m_cur].size() > 0;
            if (e_tv && tready) e_rd[m_cur] = 1'b1;
        end
        obs_tv = tvalid;
        check("rd_en", rd_en, e_rd);
        check("rd_en_w", rd_en_w, e_rd);
        check("tvalid", tvalid, e_tv);
        check("tvalid_w", tvalid_w, e_tv);
        check("out_sel", out_sel, m_cur);
        check("out_sel_w", out_sel_w, m_cur);
        m_fwd = 1'b0;
        if (e_rd != '0) begin
            t = fq[m_cur].pop_front();
            order.push_back(m_cur);
            if (!m_inpkt) m_fwd = 1'b1;
            if (t) begin
                m_inpkt = 1'b0;
                if (m_credit > 0) m_credit--;
                m_cnt[m_cur] = m_cnt[m_cur] + 1;
            end else begin
                m_inpkt = 1'b1;
            end
        end else if (!m_inpkt && !serve) begin
            found = 1'b0;
            pick = m_cur;
            for (int k = 1; k <= NQ; k++) begin
                nxt = (m_cur + k) % NQ;
                if (!found && fq[nxt].size() > 0 && wt[nxt] != 0) begin
                    found = 1'b1;
                    pick = nxt;
                end
            end
            if (found) begin
                m_cur = pick;
                m_credit = wt[pick];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int first0;
        int pat [4];
        bit sel_moved;
        pat = '{0, 0, 1, 2};
        rst_n = 1'b0;
        tready = 1'b0;
        mode = 2;
        set_w(0, 0, 0, 0, 0);
        clear_fifos();
        drive_flags();
        @(posedge clk);
        #1;

        // Weights 2,1,1 with three backlogged queues
        do_reset();
        mode = 0;
        tready = 1'b1;
        set_w(2, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) backlog[i] = 1'b1;
        for (int n = 0; n < 40; n++) step();
        first0 = -1;
        for (int i = 0; i < order.size(); i++)
            if (first0 < 0 && order[i] == 0) first0 = i;
        check("s1_first0_found", first0 >= 0 && first0 + 8 <= order.size(), 1);
        if (first0 >= 0 && first0 + 8 <= order.size())
            for (int k = 0; k < 8; k++)
                check("s1_order", order[first0 + k], pat[k % 4]);

        // Four-word packet on q0 with tready toggling, q1 waiting
        clear_fifos();
        do_reset();
        mode = 2;
        set_w(1, 1, 0, 0, 0);
        push_pkt(0, 4);
        tready = 1'b1;
        step();
        push_pkt(1, 1);
        pops = 0;
        sel_moved = 1'b0;
        for (int c = 0; c < 20 && pops < 4; c++) begin
            if (out_sel != 3'd0) sel_moved = 1'b1;
            tready = ~tready;
            step();
            pops = 0;
            foreach (order[i]) if (order[i] == 0) pops++;
        end
        check("s2_q0_pops", pops, 4);
        check("s2_sel_held", sel_moved, 0);
        tready = 1'b1;
        for (int n = 0; n < 4; n++) step();
        check("s2_cnt0", pkt_cnt[0 +: C], 1);

        // Only q2 eligible with weight 1: reload bubble every packet
        clear_fifos();
        do_reset();
        mode = 0;
        tready = 1'b1;
        set_w(0, 0, 1, 0, 0);
        backlog[2] = 1'b1;
        for (int n = 0; n < 20; n++) step();
        check("s3_pops", order.size(), 10);
        check("s3_sel", out_sel, 2);

        // q0 runs dry mid-packet for three cycles
        clear_fifos();
        do_reset();
        mode = 2;
        tready = 1'b1;
        set_w(1, 1, 0, 0, 0);
        fq[0].push_back(1'b0);
        fq[0].push_back(1'b0);
        step();
        push_pkt(1, 1);
        step();
        step();
        for (int n = 0; n < 3; n++) begin
            step();
            check("s4_tvalid_low", obs_tv, 0);
            check("s4_sel_q0", out_sel, 0);
        end
        fq[0].push_back(1'b0);
        fq[0].push_back(1'b1);
        for (int n = 0; n < 4; n++) step();
        check("s4_cnt0", pkt_cnt[0 +: C], 1);

        // Reset while the third word of a five-word packet is presented
        clear_fifos();
        do_reset();
        mode = 2;
        tready = 1'b1;
        set_w(1, 0, 0, 0, 0);
        push_pkt(0, 5);
        for (int n = 0; n < 12 && fq[0].size() > 3; n++) step();
        check("s5_mid_pkt", fq[0].size(), 3);
        do_reset();
        for (int n = 0; n < 6; n++) step();
        check("s5_cnt0", pkt_cnt[0 +: C], 1);

        // Long randomized run with weight changes and mid-packet resets
        clear_fifos();
        do_reset();
        mode = 1;
        for (int i = 0; i < NQ; i++)
            cfg_weight[i*W +: W] = W'($urandom_range(0, 3));
        for (int n = 0; n < 2500; n++) begin
            if (m_inpkt && $urandom_range(0, 299) == 0) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
